// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the 4x4 hex keypad scanner.
//   kp_state_t   : scanner FSM states
//   ROW_IDLE     : row pattern with no key pressed (rows are active-low)
//   keymap()     : (row, column) -> hex key code
//   onehot0_low(): true when exactly one row bit is low
//   low_row_idx(): index of the lowest low row bit
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [2:0] {
        SCAN      = 3'd0,
        DEB_PRESS = 3'd1,
        HELD      = 3'd2,
        WAIT_REL  = 3'd3,
        DEB_REL   = 3'd4
    } kp_state_t;

    localparam logic [3:0] ROW_IDLE = 4'hF;

    // Physical key legend, row-major:
    //   r0: 1 2 3 A / r1: 4 5 6 B / r2: 7 8 9 C / r3: 0 F E D
    function automatic logic [3:0] keymap(input logic [1:0] row_idx,
                                          input logic [1:0] col_idx);
        logic [3:0] code;
        case ({row_idx, col_idx})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic bit onehot0_low(input logic [3:0] row);
        case (row)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] low_row_idx(input logic [3:0] row);
        if (!row[0])      return 2'd0;
        else if (!row[1]) return 2'd1;
        else if (!row[2]) return 2'd2;
        else              return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchronizer for signals asynchronous to clk.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset, flops load RST_VAL
//   i_d    : asynchronous input bus
//   o_q    : synchronized output bus (2-cycle latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 hex keypad (column drive, row sense) and emits one debounced
// key event per physical press.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   row_n     : keypad rows, active-low, asynchronous to clk
//   col_n     : column drive, active-low, exactly one bit low
//   key_code  : hex code of the last accepted key
//   key_valid : one-cycle pulse when key_code updates
//   key_held  : high from accept until the release is debounced
// Scan/debounce flow: SCAN walks the columns, evaluating rows once per slot.
// A non-idle row pattern freezes the column and must stay identical for
// DEBOUNCE_CYC cycles; single-row patterns are accepted (HELD), multi-row
// patterns are swallowed (WAIT_REL). Release must be idle for DEBOUNCE_CYC
// cycles before scanning resumes at the next column.
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 27000,
    parameter int DEBOUNCE_CYC = 270000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYC);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);

    logic [3:0] w_row_s;

    sync_2ff #(.W(4), .RST_VAL(ROW_IDLE)) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (row_n),
        .o_q   (w_row_s)
    );

    kp_state_t      r_state,     w_state;
    logic [SW-1:0]  r_scnt,      w_scnt;
    logic [DW-1:0]  r_dcnt,      w_dcnt;
    logic [1:0]     r_col_idx,   w_col_idx;
    logic [3:0]     r_rpat,      w_rpat;
    logic [3:0]     r_key_code,  w_key_code;
    logic           r_key_valid, w_key_valid;
    logic           r_key_held,  w_key_held;
    logic           w_tick;

    always_comb begin
        w_state     = r_state;
        w_scnt      = r_scnt;
        w_dcnt      = r_dcnt;
        w_col_idx   = r_col_idx;
        w_rpat      = r_rpat;
        w_key_code  = r_key_code;
        w_key_valid = 1'b0;
        w_key_held  = r_key_held;
        w_tick      = (r_scnt == SCAN_LAST);

        case (r_state)
            SCAN: begin
                // Rows are only looked at once the column has settled a full slot.
                if (w_tick) begin
                    w_scnt = '0;
                    if (w_row_s == ROW_IDLE) begin
                        w_col_idx = r_col_idx + 2'd1;
                    end else begin
                        w_rpat  = w_row_s;
                        w_dcnt  = '0;
                        w_state = DEB_PRESS;
                    end
                end else begin
                    w_scnt = r_scnt + SW'(1);
                end
            end
            DEB_PRESS: begin
                if (w_row_s != r_rpat) begin
                    // Pattern changed: treat as a glitch, rescan the same column.
                    w_state = SCAN;
                    w_scnt  = '0;
                end else if (r_dcnt == DEB_LAST) begin
                    if (onehot0_low(r_rpat)) begin
                        w_key_code  = keymap(low_row_idx(r_rpat), r_col_idx);
                        w_key_valid = 1'b1;
                        w_key_held  = 1'b1;
                        w_state     = HELD;
                    end else begin
                        w_state = WAIT_REL;
                    end
                end else begin
                    w_dcnt = r_dcnt + DW'(1);
                end
            end
            HELD, WAIT_REL: begin
                if (w_row_s == ROW_IDLE) begin
                    w_dcnt  = '0;
                    w_state = DEB_REL;
                end
            end
            DEB_REL: begin
                // key_held remembers whether we came from HELD or WAIT_REL.
                if (w_row_s != ROW_IDLE) begin
                    w_state = r_key_held ? HELD : WAIT_REL;
                end else if (r_dcnt == DEB_LAST) begin
                    w_key_held = 1'b0;
                    w_col_idx  = r_col_idx + 2'd1;
                    w_scnt     = '0;
                    w_state    = SCAN;
                end else begin
                    w_dcnt = r_dcnt + DW'(1);
                end
            end
            default: begin
                w_state = SCAN;
                w_scnt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SCAN;
            r_scnt      <= '0;
            r_dcnt      <= '0;
            r_col_idx   <= 2'd0;
            r_rpat      <= ROW_IDLE;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_scnt      <= w_scnt;
            r_dcnt      <= w_dcnt;
            r_col_idx   <= w_col_idx;
            r_rpat      <= w_rpat;
            r_key_code  <= w_key_code;
            r_key_valid <= w_key_valid;
            r_key_held  <= w_key_held;
        end
    end

    assign col_n     = ~(4'b0001 << r_col_idx);
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
